// File: rtl/fifo_frame_reader.sv
// Pops words from a sync FIFO, extracts HEAD/TAIL delimited frames and streams
// their payload with sof/eof marks over a valid/ready output register.
module fifo_frame_reader #(
    parameter int unsigned           WIDTH   = 16,
    parameter logic [WIDTH-1:0]      HEAD    = 16'hFAF1,
    parameter logic [WIDTH-1:0]      TAIL    = 16'hF1FA,
    parameter int unsigned           MAX_LEN = 256,
    parameter int unsigned           LEN_W   = 9
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_done,
    output logic             frame_err
);

    typedef enum logic [1:0] {
        HUNT,
        FIRST,
        BODY
    } state_t;

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    state_t           state;
    state_t           state_nxt;

    logic             active;
    logic             pending;
    logic [WIDTH-1:0] hold_data;
    logic             hold_sof;
    logic [LEN_W-1:0] count;

    logic             is_head;
    logic             is_tail;
    logic             at_max;

    logic             emit;
    logic             emit_eof;
    logic             set_done;
    logic             set_err;
    logic             load_len;
    logic             hold_load;
    logic             hold_sof_nxt;
    logic [LEN_W-1:0] count_nxt;

    assign is_head = (fifo_rd_data == HEAD);
    assign is_tail = (fifo_rd_data == TAIL);
    assign at_max  = (count == MAX_CNT);

    // A pop is only issued when the output register is guaranteed free on arrival.
    // `active` keeps the pop request low while reset is asserted.
    assign fifo_rd_en = active && !fifo_empty && !pending && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (pending) begin
            case (state)
                HUNT: begin
                    if (is_head) state_nxt = FIRST;
                end
                FIRST: begin
                    if (is_tail)       state_nxt = HUNT;
                    else if (is_head)  state_nxt = FIRST;
                    else               state_nxt = BODY;
                end
                BODY: begin
                    if (is_tail)       state_nxt = HUNT;
                    else if (is_head)  state_nxt = FIRST;
                    else if (at_max)   state_nxt = HUNT;
                    else               state_nxt = BODY;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_comb begin
        emit         = 1'b0;
        emit_eof     = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        load_len     = 1'b0;
        hold_load    = 1'b0;
        hold_sof_nxt = 1'b0;
        count_nxt    = count;
        if (pending) begin
            case (state)
                FIRST: begin
                    if (is_tail) begin
                        set_err = 1'b1;
                    end else if (!is_head) begin
                        hold_load    = 1'b1;
                        hold_sof_nxt = 1'b1;
                        count_nxt    = LEN_W'(1);
                    end
                end
                BODY: begin
                    // The held word is only known to be last once the next word arrives.
                    emit = 1'b1;
                    if (is_tail) begin
                        emit_eof = 1'b1;
                        load_len = 1'b1;
                        set_done = 1'b1;
                    end else if (is_head || at_max) begin
                        emit_eof = 1'b1;
                        load_len = 1'b1;
                        set_err  = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        count_nxt = count + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active     <= 1'b0;
            pending    <= 1'b0;
            hold_data  <= '0;
            hold_sof   <= 1'b0;
            count      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            active     <= 1'b1;
            pending    <= fifo_rd_en;
            count      <= count_nxt;
            frame_done <= set_done;
            frame_err  <= set_err;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= hold_data;
                out_sof   <= hold_sof;
                out_eof   <= emit_eof;
            end
            if (hold_load) begin
                hold_data <= fifo_rd_data;
                hold_sof  <= hold_sof_nxt;
            end
            if (load_len) begin
                frame_len <= count;
            end
        end
    end

endmodule
